// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO peripheral.
//   - register byte offsets inside the slave window
//   - window size and blink-period register width
//   - bus request struct used by the top-level decode
`timescale 1ns/1ps
package wb_gpio_pkg;
  localparam logic [7:0] LED_OFS          = 8'h00;
  localparam logic [7:0] LED_SET_OFS      = 8'h04;
  localparam logic [7:0] LED_CLR_OFS      = 8'h08;
  localparam logic [7:0] LED_TGL_OFS      = 8'h0C;
  localparam logic [7:0] BTN_OFS          = 8'h10;
  localparam logic [7:0] IRQ_STATUS_OFS   = 8'h14;
  localparam logic [7:0] IRQ_ENABLE_OFS   = 8'h18;
  localparam logic [7:0] BLINK_MASK_OFS   = 8'h1C;
  localparam logic [7:0] BLINK_PERIOD_OFS = 8'h20;

  localparam logic [31:0] WINDOW_BYTES   = 32'h24;
  localparam int          BLINK_PERIOD_W = 24;

  // One decoded bus access for the current cycle.
  typedef struct packed {
    logic        vld;   // cyc & stb & address inside the window
    logic        we;
    logic [7:0]  ofs;   // byte offset from BASE_ADDR
    logic [31:0] data;
  } bus_req_t;
endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser followed by a debounce counter.
//   clk, reset_n : clock, async active-low reset
//   btn_in       : raw asynchronous button level (1 = pressed)
//   stable       : debounced level
// The counter runs while the synchronised input disagrees with the
// debounced state; once it has reached DEBOUNCE_CYCLES the state flips on
// the following edge, giving a latency of 2 + DEBOUNCE_CYCLES edges.
`timescale 1ns/1ps
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/wb_buttons_leds_v2.sv
// Wishbone slave GPIO: NUM_LEDS LEDs with set/clear/toggle and blink,
// NUM_BUTTONS debounced buttons with sticky press interrupts.
//   clk, reset_n          : clock, async active-low reset
//   i_wb_* / o_wb_*       : Wishbone slave, single-cycle registered ack
//   buttons               : raw button levels
//   led_enb, leds         : LED enable (always on, active low) and drive
//   o_irq                 : |(IRQ_STATUS & IRQ_ENABLE)
`timescale 1ns/1ps
module wb_buttons_leds_v2
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_LEDS        = 2,
  parameter int          NUM_BUTTONS     = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  output logic                   o_wb_ack,
  output logic                   o_wb_stall,
  output logic [31:0]            o_wb_data,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    led_enb,
  output logic [NUM_LEDS-1:0]    leds,
  output logic                   o_irq
);
  localparam logic [BLINK_PERIOD_W-1:0] PRESC_ONE = BLINK_PERIOD_W'(1);

  // Subtracting the base lets a single unsigned compare cover both window
  // edges: addresses below BASE_ADDR wrap to huge offsets.
  logic [31:0] ofs;
  bus_req_t    req;
  assign ofs = i_wb_addr - BASE_ADDR;

  always_comb begin
    req.vld  = i_wb_cyc & i_wb_stb & (ofs < WINDOW_BYTES);
    req.we   = i_wb_we;
    req.ofs  = ofs[7:0];
    req.data = i_wb_data;
  end

  logic                   wr;
  logic [NUM_LEDS-1:0]    wd_led;
  logic [NUM_BUTTONS-1:0] wd_btn;
  assign wr     = req.vld & req.we;
  assign wd_led = req.data[NUM_LEDS-1:0];
  assign wd_btn = req.data[NUM_BUTTONS-1:0];

  // Debounced buttons, one channel per instance.
  logic [NUM_BUTTONS-1:0] btn_db;
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (buttons[g]),
      .stable  (btn_db[g])
    );
  end

  logic [NUM_LEDS-1:0]       led_q, led_d;
  logic [NUM_LEDS-1:0]       blink_mask_q, blink_mask_d;
  logic [NUM_BUTTONS-1:0]    irq_sts_q, irq_sts_d;
  logic [NUM_BUTTONS-1:0]    irq_en_q, irq_en_d;
  logic [NUM_BUTTONS-1:0]    btn_prev_q, btn_prev_d;
  logic [BLINK_PERIOD_W-1:0] period_q, period_d;
  logic [BLINK_PERIOD_W-1:0] presc_q, presc_d;
  logic                      phase_q, phase_d;
  logic                      ack_q, ack_d;
  logic [31:0]               rdata_q, rdata_d;

  logic [NUM_BUTTONS-1:0] rise, irq_clr;
  logic                   period_wr;

  always_comb begin
    led_d        = led_q;
    blink_mask_d = blink_mask_q;
    irq_en_d     = irq_en_q;
    period_d     = period_q;
    irq_clr      = '0;
    period_wr    = 1'b0;
    if (wr) begin
      case (req.ofs)
        LED_OFS:          led_d        = wd_led;
        LED_SET_OFS:      led_d        = led_q | wd_led;
        LED_CLR_OFS:      led_d        = led_q & ~wd_led;
        LED_TGL_OFS:      led_d        = led_q ^ wd_led;
        IRQ_STATUS_OFS:   irq_clr      = wd_btn;
        IRQ_ENABLE_OFS:   irq_en_d     = wd_btn;
        BLINK_MASK_OFS:   blink_mask_d = wd_led;
        BLINK_PERIOD_OFS: begin
          period_d  = req.data[BLINK_PERIOD_W-1:0];
          period_wr = 1'b1;
        end
        default: ;
      endcase
    end

    // A press edge in the same cycle as a W1C of that bit keeps it set.
    btn_prev_d = btn_db;
    rise       = btn_db & ~btn_prev_q;
    irq_sts_d  = (irq_sts_q & ~irq_clr) | rise;

    presc_d = presc_q + PRESC_ONE;
    phase_d = phase_q;
    if (period_wr) begin
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == period_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end

    // Read data reflects state before this cycle's write.
    ack_d   = req.vld;
    rdata_d = '0;
    if (req.vld && !req.we) begin
      case (req.ofs)
        LED_OFS:          rdata_d = 32'(led_q);
        BTN_OFS:          rdata_d = 32'(btn_db);
        IRQ_STATUS_OFS:   rdata_d = 32'(irq_sts_q);
        IRQ_ENABLE_OFS:   rdata_d = 32'(irq_en_q);
        BLINK_MASK_OFS:   rdata_d = 32'(blink_mask_q);
        BLINK_PERIOD_OFS: rdata_d = 32'(period_q);
        default:          rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q        <= '0;
      blink_mask_q <= '0;
      irq_sts_q    <= '0;
      irq_en_q     <= '0;
      btn_prev_q   <= '0;
      period_q     <= '0;
      presc_q      <= '0;
      phase_q      <= 1'b1;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      led_q        <= led_d;
      blink_mask_q <= blink_mask_d;
      irq_sts_q    <= irq_sts_d;
      irq_en_q     <= irq_en_d;
      btn_prev_q   <= btn_prev_d;
      period_q     <= period_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign led_enb    = '0;
  assign leds       = led_q & (~blink_mask_q | {NUM_LEDS{phase_q}});
  assign o_irq      = |(irq_sts_q & irq_en_q);

  // Upper data/offset bits have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{req.data, ofs};
endmodule

// File: tb/tb_wb_buttons_leds_v2.sv
`timescale 1ns/1ps
module tb_wb_buttons_leds_v2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        o_ack, o_stall, o_irq;
  logic [31:0] o_data;
  logic [3:0]  buttons = '0;
  logic [3:0]  led_enb, leds;

  always #5 clk = ~clk;

  wb_buttons_leds_v2 #(
    .NUM_LEDS(4), .NUM_BUTTONS(4), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(o_ack), .o_wb_stall(o_stall), .o_wb_data(o_data),
    .buttons(buttons), .led_enb(led_enb), .leds(leds), .o_irq(o_irq)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Single access; returns at the negedge after the accepting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic ak, output logic [31:0] rd);
    @(negedge clk); cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    @(posedge clk); #1; cyc = 0; stb = 0; we = 0;
    @(negedge clk); ak = o_ack; rd = o_data;
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] d, input string name);
    logic ak; logic [31:0] rd;
    bus(1'b1, BASE + ofs, d, ak, rd);
    chk({name, "_ack"}, 32'(ak), 32'd1);
  endtask

  task automatic rd_chk(input logic [31:0] ofs, input logic [31:0] exp, input string name);
    logic ak; logic [31:0] rd;
    bus(1'b0, BASE + ofs, 32'h0, ak, rd);
    chk({name, "_ack"}, 32'(ak), 32'd1);
    chk(name, rd, exp);
  endtask

  // Back-to-back BTN reads starting with the edge that first samples val.
  // Sample n sees the value held after edge n-1, so the debounced change
  // at edge 6 (2 sync + 4 debounce) shows from n = 7.
  task automatic btn_watch(input logic [3:0] val, input string name);
    @(negedge clk); reset_n = 1; buttons = val;
    cyc = 1; stb = 1; we = 0; addr = BASE + 32'h10;
    for (int n = 0; n < 9; n++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s_ack%0d", name, n), 32'(o_ack), 32'd1);
      chk($sformatf("%s_n%0d", name, n), o_data, (n >= 7) ? 32'(val) : 32'h0);
    end
    cyc = 0; stb = 0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] ofs;
    logic [31:0] d;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic ak; logic [31:0] rd;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_data", o_data, 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_irq", 32'(o_irq), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_led_enb", 32'(led_enb), 0);
    @(negedge clk); reset_n = 1;

    // Register access table
    for (int i = 0; i < 9; i++) vecs.push_back('{1'b0, 32'(i * 4), 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 32'h5, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h04, 32'h2, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 32'h4, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0C, 32'h9, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'hA});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h1C, 32'hFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0, 1'b1, 32'hF});
    vecs.push_back('{1'b1, 32'h1C, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 1'b1, 32'h00FF_FFFF});
    vecs.push_back('{1'b1, 32'h18, 32'hFFFF_FFF0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h18, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h10, 32'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h40, 32'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h24, 32'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h24, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'hA});
    foreach (vecs[i]) begin
      bus(vecs[i].w, BASE + vecs[i].ofs, vecs[i].d, ak, rd);
      chk($sformatf("vec%0d_ack", i), 32'(ak), 32'(vecs[i].exp_ack));
      if (!vecs[i].w && vecs[i].exp_ack) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end
    chk("leds_after_table", 32'(leds), 32'hA);

    // 3-cycle glitch is rejected
    @(negedge clk); buttons = 4'h2;
    repeat (3) @(posedge clk);
    @(negedge clk); buttons = 4'h0;
    repeat (10) @(posedge clk);
    rd_chk(32'h10, 32'h0, "glitch_btn");

    // Held press: exact debounce latency, then sticky status
    btn_watch(4'h2, "press");
    chk("press_irq_masked", 32'(o_irq), 0);
    rd_chk(32'h14, 32'h2, "press_sts");
    chk("sts_irq_masked", 32'(o_irq), 0);
    wr(32'h18, 32'h2, "en");
    chk("irq_enabled", 32'(o_irq), 1);
    wr(32'h14, 32'h2, "w1c");
    chk("irq_after_w1c", 32'(o_irq), 0);
    rd_chk(32'h14, 32'h0, "sts_after_w1c");

    // Release: no interrupt on the falling edge
    @(negedge clk); buttons = 4'h0;
    repeat (12) @(posedge clk);
    rd_chk(32'h10, 32'h0, "release_btn");
    rd_chk(32'h14, 32'h0, "release_sts");

    // New press with a W1C landing on the same edge the status sets
    @(negedge clk); buttons = 4'h2;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("coinc_irq_before", 32'(o_irq), 0);
    cyc = 1; stb = 1; we = 1; addr = BASE + 32'h14; wdata = 32'h2;
    @(posedge clk); #1; cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("coinc_ack", 32'(o_ack), 1);
    chk("coinc_irq", 32'(o_irq), 1);
    rd_chk(32'h14, 32'h2, "coinc_sts");
    wr(32'h14, 32'h2, "w1c2");
    chk("irq_after_w1c2", 32'(o_irq), 0);

    // Blink: period 3 -> phase flips every 4 cycles
    wr(32'h1C, 32'h1, "mask");
    wr(32'h00, 32'h3, "led3");
    wr(32'h20, 32'h3, "per3");
    for (int m = 0; m < 12; m++) begin
      if (m > 0) @(negedge clk);
      chk($sformatf("blink3_m%0d", m), 32'(leds), (((m / 4) % 2) == 0) ? 32'h3 : 32'h2);
    end
    wr(32'h20, 32'h0, "per0");
    for (int m = 0; m < 6; m++) begin
      if (m > 0) @(negedge clk);
      chk($sformatf("blink0_m%0d", m), 32'(leds), ((m % 2) == 0) ? 32'h3 : 32'h2);
    end

    // Reset part-way through a debounce; count must restart from scratch
    @(negedge clk); buttons = 4'h4;
    repeat (4) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    chk("mid_rst_leds", 32'(leds), 0);
    chk("mid_rst_irq", 32'(o_irq), 0);
    chk("mid_rst_ack", 32'(o_ack), 0);
    chk("mid_rst_data", o_data, 0);
    repeat (2) @(negedge clk);
    btn_watch(4'h4, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
